// File: rtl/block_transfer_arbiter_if.sv
// Requester, return-stream and engine signals shared between the block transfer
// arbiter (slave) and its surroundings (master: requester FIFOs plus block engine).
interface block_transfer_arbiter_if #(
    parameter int WSIZE = 32,
    parameter int WPB   = 4,
    parameter int NREQ  = 4
);
    localparam int BSIZE = WSIZE * WPB;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WSIZE-1:0] req_word;
    logic [NREQ-1:0]       req_pull;
    logic [WSIZE-1:0]      resp_word;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_hold;
    logic [BSIZE-1:0]      eng_block_out;
    logic                  eng_start;
    logic                  eng_done;
    logic [BSIZE-1:0]      eng_block_in;

    modport master (
        output req_valid, req_word, resp_hold, eng_done, eng_block_in,
        input  req_pull, resp_word, resp_valid, eng_block_out, eng_start
    );

    modport slave (
        input  req_valid, req_word, resp_hold, eng_done, eng_block_in,
        output req_pull, resp_word, resp_valid, eng_block_out, eng_start
    );
endinterface

// File: rtl/block_transfer_arbiter.sv
// Round-robin sharing of one block engine among NREQ word-stream requesters:
// gather WPB words, launch the engine, then stream the result back word by word.
module block_transfer_arbiter #(
    parameter  int WSIZE = 32,
    parameter  int WPB   = 4,
    parameter  int NREQ  = 4,
    localparam int BSIZE = WSIZE * WPB,
    localparam int GW    = $clog2(NREQ),
    localparam int CW    = $clog2(WPB)
) (
    input  logic                    clock,
    input  logic                    reset,
    block_transfer_arbiter_if.slave bus,
    output logic [GW-1:0]           grant,
    output logic                    busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_GATHER,
        S_ISSUE,
        S_WAIT,
        S_RETURN
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    last;
    logic [BSIZE-1:0] gather_block;
    logic [BSIZE-1:0] result_block;

    logic             found;
    logic [GW-1:0]    next_grant;
    logic [GW-1:0]    cand;
    int               slot_lsb;

    // Slot 0 is the most significant word of a block.
    assign slot_lsb = (WPB - 1 - int'(cnt)) * WSIZE;

    // Search starts just after the last served requester; offset NREQ wraps to last itself.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        found      = 1'b0;
        next_grant = '0;
        cand       = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = last + GW'(off);
            if (!found && bus.req_valid[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
        end
    end

    always_comb begin
        bus.req_pull   = '0;
        bus.resp_valid = '0;
        if (state == S_GATHER) bus.req_pull[grant] = bus.req_valid[grant];
        if (state == S_RETURN) bus.resp_valid[grant] = 1'b1;
    end

    assign bus.eng_start     = (state == S_ISSUE);
    assign bus.eng_block_out = (state == S_ISSUE || state == S_WAIT) ? gather_block : '0;
    assign bus.resp_word     = (state == S_RETURN) ? result_block[slot_lsb +: WSIZE] : '0;
    assign busy              = (state != S_IDLE);

    // NOTE: the block registers are plain flops, so they are cleared by reset with the
    // rest of the state; that keeps a discarded partial block from ever resurfacing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            last         <= GW'(NREQ - 1);
            grant        <= '0;
            gather_block <= '0;
            result_block <= '0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees pre-edge values of cnt/state.
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant <= next_grant;
                        state <= S_GATHER;
                    end
                end
                S_GATHER: begin
                    if (bus.req_valid[grant]) begin
                        gather_block[slot_lsb +: WSIZE] <= bus.req_word[int'(grant)*WSIZE +: WSIZE];
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WPB - 1)) state <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.eng_done) begin
                        result_block <= bus.eng_block_in;
                        state        <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    if (!bus.resp_hold[grant]) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WPB - 1)) begin
                            last  <= grant;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_transfer_arbiter.sv
// Directed bench for block_transfer_arbiter with an inverting engine model
// (result block = ~issued block) and hand-computed cycle counts.
module tb_block_transfer_arbiter;
    localparam int WSIZE = 32;
    localparam int WPB   = 4;
    localparam int NREQ  = 4;
    localparam int BSIZE = WSIZE * WPB;
    localparam int GW    = 2;

    typedef logic [WSIZE-1:0] word_t;
    typedef word_t words_t [WPB];

    logic          clock = 1'b0;
    logic          reset;
    logic [GW-1:0] grant;
    logic          busy;

    int checks = 0;
    int errors = 0;

    int eng_delay = 1;
    bit eng_auto  = 1'b1;
    int pend      = 0;

    bit cfg_keep;
    int cfg_gap_at, cfg_gap_n, cfg_hold_at, cfg_hold_n, cfg_abort_g, cfg_abort_r;
    bit cfg_manual;

    block_transfer_arbiter_if #(.WSIZE(WSIZE), .WPB(WPB), .NREQ(NREQ)) bus ();

    block_transfer_arbiter #(.WSIZE(WSIZE), .WPB(WPB), .NREQ(NREQ)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    // Engine model: raises eng_done in the eng_delay-th WAIT cycle with the inverted block.
    initial begin
        forever begin
            @(negedge clock);
            if (eng_auto) begin
                bus.eng_done = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.eng_done     = 1'b1;
                        bus.eng_block_in = ~bus.eng_block_out;
                    end
                end
                if (bus.eng_start) pend = eng_delay;
            end
        end
    end

    function automatic words_t mk(input word_t base);
        for (int k = 0; k < WPB; k++) mk[k] = base + word_t'(k) * 32'h0101_0101;
    endfunction

    task automatic cfg_default();
        cfg_keep    = 1'b0;
        cfg_gap_at  = -1;
        cfg_gap_n   = 0;
        cfg_hold_at = -1;
        cfg_hold_n  = 0;
        cfg_abort_g = -1;
        cfg_abort_r = -1;
        cfg_manual  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset         = 1'b1;
        pend          = 0;
        bus.req_valid = '0;
        bus.resp_hold = '0;
        bus.eng_done  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One full transaction for requester r; called at a negedge while the DUT is in IDLE.
    task automatic do_block(input int r, input words_t w, output int cycles);
        logic [BSIZE-1:0] blk;
        logic [NREQ-1:0]  onehot;
        bit               got;
        blk = '0;
        for (int k = 0; k < WPB; k++) blk[(WPB-1-k)*WSIZE +: WSIZE] = w[k];
        onehot    = '0;
        onehot[r] = 1'b1;
        cycles    = 0;

        bus.req_valid[r] = 1'b1;
        bus.req_word[r*WSIZE +: WSIZE] = w[0];
        @(negedge clock); cycles++;
        #1;
        checks++;
        if (grant !== GW'(r) || busy !== 1'b1) begin
            errors++;
            $display("FAIL grant: got %0d busy %b, expected %0d busy 1", grant, busy, r);
        end

        for (int k = 0; k < WPB; k++) begin
            if (k == cfg_gap_at) begin
                for (int g = 0; g < cfg_gap_n; g++) begin
                    bus.req_valid[r] = 1'b0;
                    #1;
                    checks++;
                    if (bus.req_pull !== '0 || grant !== GW'(r) || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL gather_stall: req_pull %b grant %0d busy %b, expected 0000 grant %0d busy 1",
                                 bus.req_pull, grant, busy, r);
                    end
                    @(negedge clock); cycles++;
                end
                bus.req_valid[r] = 1'b1;
            end
            if (k == cfg_abort_g) return;
            bus.req_word[r*WSIZE +: WSIZE] = w[k];
            #1;
            checks++;
            if (bus.req_pull !== onehot) begin
                errors++;
                $display("FAIL req_pull word %0d: got %b, expected %b", k, bus.req_pull, onehot);
            end
            @(negedge clock); cycles++;
        end

        if (!cfg_keep) bus.req_valid[r] = 1'b0;
        #1;
        checks++;
        if (bus.eng_start !== 1'b1 || bus.eng_block_out !== blk || bus.req_pull !== '0) begin
            errors++;
            $display("FAIL issue: eng_start %b block %h req_pull %b, expected 1 block %h req_pull 0000",
                     bus.eng_start, bus.eng_block_out, bus.req_pull, blk);
        end

        if (cfg_manual) begin
            bus.eng_block_in = {4{32'hDEAD_BEEF}};
            bus.eng_done     = 1'b1;
            @(negedge clock); cycles++;
            bus.eng_block_in = ~blk;
            #1;
            checks++;
            if (bus.resp_valid !== '0 || busy !== 1'b1 || bus.eng_start !== 1'b0) begin
                errors++;
                $display("FAIL done_in_issue: resp_valid %b busy %b eng_start %b, expected 0000 1 0",
                         bus.resp_valid, busy, bus.eng_start);
            end
        end

        got = 1'b0;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clock); cycles++;
            if (cfg_manual) bus.eng_done = 1'b0;
            #1;
            if (bus.resp_valid !== '0) got = 1'b1;
            else begin
                checks++;
                if (bus.eng_start !== 1'b0 || bus.req_pull !== '0 || bus.eng_block_out !== blk) begin
                    errors++;
                    $display("FAIL wait: eng_start %b req_pull %b block %h, expected 0 0000 %h",
                             bus.eng_start, bus.req_pull, bus.eng_block_out, blk);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout: resp_valid still %b after 64 cycles, expected %b", bus.resp_valid, onehot);
            return;
        end

        for (int k = 0; k < WPB; k++) begin
            if (k > 0) begin
                @(negedge clock); cycles++;
                #1;
            end
            if (k == cfg_abort_r) return;
            checks++;
            if (bus.resp_valid !== onehot || bus.resp_word !== ~w[k]) begin
                errors++;
                $display("FAIL resp word %0d: valid %b word %h, expected %b %h",
                         k, bus.resp_valid, bus.resp_word, onehot, ~w[k]);
            end
            if (k == cfg_hold_at) begin
                for (int h = 0; h < cfg_hold_n; h++) begin
                    bus.resp_hold[r] = 1'b1;
                    @(negedge clock); cycles++;
                    #1;
                    checks++;
                    if (bus.resp_valid !== onehot || bus.resp_word !== ~w[k]) begin
                        errors++;
                        $display("FAIL resp_hold word %0d: valid %b word %h, expected %b %h",
                                 k, bus.resp_valid, bus.resp_word, onehot, ~w[k]);
                    end
                end
                bus.resp_hold[r] = 1'b0;
            end
        end

        @(negedge clock); cycles++;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.resp_valid !== '0) begin
            errors++;
            $display("FAIL back_to_idle: busy %b resp_valid %b, expected 0 0000", busy, bus.resp_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || grant !== '0 || bus.req_pull !== '0 || bus.resp_valid !== '0 ||
            bus.eng_start !== 1'b0 || bus.eng_block_out !== '0 || bus.resp_word !== '0) begin
            errors++;
            $display("FAIL reset_state: busy %b grant %0d pull %b rvalid %b start %b blk %h word %h, expected all 0",
                     busy, grant, bus.req_pull, bus.resp_valid, bus.eng_start, bus.eng_block_out, bus.resp_word);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || bus.req_pull !== '0) begin
            errors++;
            $display("FAIL idle_no_request: busy %b req_pull %b, expected 0 0000", busy, bus.req_pull);
        end
    endtask

    task automatic test_single();
        int c;
        words_t a;
        a = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
        cfg_default();
        eng_delay = 3;
        do_block(2, a, c);
        checks++;
        if (c !== 13) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, expected 13", c);
        end
        eng_delay = 1;
    endtask

    task automatic test_back_to_back();
        int c;
        cfg_default();
        for (int i = 0; i < 2; i++) begin
            do_block(0, mk(32'h0B00_0000 + 32'(i)), c);
            checks++;
            if (c !== 2*WPB + 3) begin
                errors++;
                $display("FAIL back_to_back %0d: got %0d cycles, expected %0d", i, c, 2*WPB + 3);
            end
        end
    endtask

    task automatic test_resp_hold();
        int c;
        cfg_default();
        bus.resp_hold = 4'b1110;
        cfg_hold_at   = 2;
        cfg_hold_n    = 2;
        do_block(0, mk(32'h4400_0040), c);
        checks++;
        if (c !== 2*WPB + 3 + 2) begin
            errors++;
            $display("FAIL hold_latency: got %0d cycles, expected %0d", c, 2*WPB + 5);
        end
        bus.resp_hold = '0;
    endtask

    task automatic test_round_robin();
        int c;
        apply_reset();
        cfg_default();
        cfg_keep      = 1'b1;
        bus.req_valid = 4'b1111;
        for (int r = 0; r < NREQ; r++) bus.req_word[r*WSIZE +: WSIZE] = 32'h5555_0000 + 32'(r);
        for (int i = 0; i < 8; i++) do_block(i % NREQ, mk(32'h6000_0000 + 32'(i) * 32'h10), c);
        bus.req_valid = '0;
    endtask

    task automatic test_gather_gap();
        int c;
        cfg_default();
        bus.req_valid[3] = 1'b1;
        bus.req_word[3*WSIZE +: WSIZE] = 32'h3333_3333;
        cfg_gap_at = 2;
        cfg_gap_n  = 3;
        do_block(1, mk(32'h7100_0001), c);
        checks++;
        if (c !== 2*WPB + 3 + 3) begin
            errors++;
            $display("FAIL gap_latency: got %0d cycles, expected %0d", c, 2*WPB + 6);
        end
        cfg_default();
        do_block(3, mk(32'h7300_0003), c);
        bus.req_valid = '0;
    endtask

    task automatic test_eng_done_ignored();
        int c;
        cfg_default();
        eng_auto         = 1'b0;
        bus.eng_block_in = {4{32'hBAD0_BAD0}};
        bus.eng_done     = 1'b1;
        @(negedge clock);
        bus.eng_done = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.resp_valid !== '0) begin
            errors++;
            $display("FAIL done_in_idle: busy %b resp_valid %b, expected 0 0000", busy, bus.resp_valid);
        end
        cfg_manual = 1'b1;
        do_block(2, mk(32'h8800_0008), c);
        checks++;
        if (c !== 2*WPB + 3) begin
            errors++;
            $display("FAIL manual_latency: got %0d cycles, expected %0d", c, 2*WPB + 3);
        end
        cfg_default();
        eng_auto = 1'b1;
    endtask

    task automatic test_reset_mid();
        int c;
        for (int phase = 0; phase < 2; phase++) begin
            apply_reset();
            cfg_default();
            if (phase == 0) cfg_abort_g = 2;
            else            cfg_abort_r = 1;
            do_block(phase == 0 ? 2 : 1, mk(32'hEE00_0000 + 32'(phase)), c);
            reset         = 1'b1;
            pend          = 0;
            bus.req_valid = '0;
            #1;
            checks++;
            if (busy !== 1'b0 || grant !== '0 || bus.req_pull !== '0 || bus.resp_valid !== '0 ||
                bus.eng_start !== 1'b0 || bus.eng_block_out !== '0 || bus.resp_word !== '0) begin
                errors++;
                $display("FAIL reset_mid phase %0d: busy %b grant %0d pull %b rvalid %b start %b blk %h word %h, expected all 0",
                         phase, busy, grant, bus.req_pull, bus.resp_valid, bus.eng_start, bus.eng_block_out, bus.resp_word);
            end
            @(negedge clock);
            reset = 1'b0;
            cfg_default();
            bus.req_valid[phase == 0 ? 2 : 3] = 1'b1;
            do_block(0, mk(32'hC000_0C00 + 32'(phase)), c);
            do_block(phase == 0 ? 2 : 3, mk(32'hD000_0D00 + 32'(phase)), c);
            bus.req_valid = '0;
        end
    endtask

    initial begin
        bus.req_valid    = '0;
        bus.req_word     = '0;
        bus.resp_hold    = '0;
        bus.eng_done     = 1'b0;
        bus.eng_block_in = '0;
        cfg_default();

        test_reset();
        test_single();
        test_back_to_back();
        test_resp_hold();
        test_round_robin();
        test_gather_gap();
        test_eng_done_ignored();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
